// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter.
// Frame: start bit, 5..DBIT_MAX data bits LSB first, optional parity, 1 or 2 stop bits.
// Paced by s_tick, which pulses OVERSAMPLE times per bit period.
// Build option: define UART_TX_PARITY_EN to include the parity bit support;
// without it cfg_parity is ignored and every frame is sent without parity.
module uart_tx_cfg #(
  parameter int DBIT_MAX   = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            tx_start,
  input  logic                            s_tick,
  input  logic [DBIT_MAX-1:0]             tx_din,
  input  logic [$clog2(DBIT_MAX+1)-1:0]   cfg_dbits,
  input  logic [1:0]                      cfg_parity,
  input  logic                            cfg_stop2,
  output logic                            tx_busy,
  output logic                            tx_done_tick,
  output logic                            tx
);

  localparam int DW = $clog2(DBIT_MAX + 1);
  localparam int TW = $clog2(2 * OVERSAMPLE);

  localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] STOP2_LAST = TW'(2 * OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t              state, state_next;
  logic [TW-1:0]       tick_cnt, tick_next;
  logic [DW-1:0]       bit_idx, idx_next;
  logic [DBIT_MAX-1:0] shift_reg, shift_next;
  logic [DW-1:0]       dbits_reg, dbits_next;
  logic                stop2_reg, stop2_next;
  logic                tx_next, done_next, busy_next;
  logic [DW-1:0]       dbits_clamp;

`ifdef UART_TX_PARITY_EN
  logic                par_en, par_en_next;
  logic                par_bit, par_next;
  logic [DBIT_MAX-1:0] data_mask;
`else
  logic                unused_cfg_parity;
  assign unused_cfg_parity = ^cfg_parity;
`endif

  // Clamp the requested word length into the supported 5..DBIT_MAX range.
  always_comb begin
    if (cfg_dbits < DW'(5)) begin
      dbits_clamp = DW'(5);
    end else if (cfg_dbits > DW'(DBIT_MAX)) begin
      dbits_clamp = DW'(DBIT_MAX);
    end else begin
      dbits_clamp = cfg_dbits;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Mask selecting only the data bits that will actually be sent, for parity.
  always_comb begin
    data_mask = '0;
    for (int i = 0; i < DBIT_MAX; i++) begin
      data_mask[i] = (i < int'(dbits_clamp));
    end
  end
`endif

  // Next-state logic; registered outputs are derived from the next state so they track it.
  always_comb begin
    state_next = state;
    tick_next  = tick_cnt;
    idx_next   = bit_idx;
    shift_next = shift_reg;
    dbits_next = dbits_reg;
    stop2_next = stop2_reg;
    done_next  = 1'b0;
    tx_next    = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_en_next = par_en;
    par_next    = par_bit;
`endif
    case (state)
      IDLE: begin
        if (tx_start) begin
          state_next = START;
          tick_next  = '0;
          shift_next = tx_din;
          dbits_next = dbits_clamp;
          stop2_next = cfg_stop2;
`ifdef UART_TX_PARITY_EN
          par_en_next = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          par_next    = (^(tx_din & data_mask)) ^ cfg_parity[1];
`endif
        end
      end
      START: begin
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_next  = '0;
            idx_next   = '0;
            state_next = DATA;
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_next  = '0;
            shift_next = shift_reg >> 1;
            idx_next   = bit_idx + DW'(1);
            if (bit_idx == dbits_reg - DW'(1)) begin
`ifdef UART_TX_PARITY_EN
              state_next = par_en ? PARITY : STOP;
`else
              state_next = STOP;
`endif
            end
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (s_tick) begin
          if (tick_cnt == BIT_LAST) begin
            tick_next  = '0;
            state_next = STOP;
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (s_tick) begin
          if (tick_cnt == (stop2_reg ? STOP2_LAST : BIT_LAST)) begin
            tick_next  = '0;
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            tick_next = tick_cnt + TW'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        tick_next  = '0;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_next = par_next;
`endif
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
  end

  // State register and frame datapath; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      dbits_reg <= '0;
      stop2_reg <= 1'b0;
    end else begin
      state     <= state_next;
      tick_cnt  <= tick_next;
      bit_idx   <= idx_next;
      shift_reg <= shift_next;
      dbits_reg <= dbits_next;
      stop2_reg <= stop2_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  // Parity enable and parity bit are captured once at frame start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_en  <= 1'b0;
      par_bit <= 1'b0;
    end else begin
      par_en  <= par_en_next;
      par_bit <= par_next;
    end
  end
`endif

  // Registered outputs so the pad sees a glitch-free line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      tx           <= tx_next;
      tx_busy      <= busy_next;
      tx_done_tick <= done_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for uart_tx_cfg (OVERSAMPLE=16, DBIT_MAX=8).
// Parity expectations follow UART_TX_PARITY_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_uart_tx_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic       tx_start;
  logic       s_tick;
  logic [7:0] tx_din;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic       cfg_stop2;
  logic       tx_busy;
  logic       tx_done_tick;
  logic       tx;

  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int total_cnt = 0;

  uart_tx_cfg #(
    .DBIT_MAX   (8),
    .OVERSAMPLE (16)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .tx_start     (tx_start),
    .s_tick       (s_tick),
    .tx_din       (tx_din),
    .cfg_dbits    (cfg_dbits),
    .cfg_parity   (cfg_parity),
    .cfg_stop2    (cfg_stop2),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .tx           (tx)
  );

  // 100 MHz system clock.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One s_tick pulse, preceded by an idle clock; returns 1ns after the tick edge.
  task automatic do_tick();
    @(posedge clk);
    #1 s_tick = 1'b1;
    @(posedge clk);
    #1 s_tick = 1'b0;
  endtask

  // Request a frame and confirm the start bit appears on the very next clock.
  task automatic apply_stimulus(input string tag, input logic [7:0] din, input logic [3:0] dbits,
                                input logic [1:0] par, input logic stop2);
    tx_din     = din;
    cfg_dbits  = dbits;
    cfg_parity = par;
    cfg_stop2  = stop2;
    tx_start   = 1'b1;
    @(posedge clk);
    #1 tx_start = 1'b0;
    check_output({tag, " start tx"}, 32'(tx), 32'd0);
    check_output({tag, " start busy"}, 32'(tx_busy), 32'd1);
    check_output({tag, " start done"}, 32'(tx_done_tick), 32'd0);
  endtask

  // Walk a started frame: seq holds start/data/parity levels LSB first, sampled mid-bit.
  task automatic run_frame(input string tag, input logic [15:0] seq, input int nseq,
                           input int exp_ticks, input int inject_bit);
    int ticks;
    ticks = 0;
    for (int b = 0; b < nseq; b++) begin
      repeat (8) begin
        do_tick();
        ticks++;
      end
      check_output($sformatf("%s bit%0d", tag, b), 32'(tx), 32'(seq[b]));
      check_output($sformatf("%s busy%0d", tag, b), 32'(tx_busy), 32'd1);
      if (b == inject_bit) begin
        tx_din     = 8'h00;
        cfg_stop2  = 1'b1;
        cfg_dbits  = 4'd5;
        tx_start   = 1'b1;
        @(posedge clk);
        #1 tx_start = 1'b0;
      end
      repeat (8) begin
        do_tick();
        ticks++;
      end
    end
    while (tx_done_tick !== 1'b1 && ticks < exp_ticks + 40) begin
      do_tick();
      ticks++;
      if (tx_done_tick !== 1'b1) begin
        check_output({tag, " stop tx"}, 32'(tx), 32'd1);
      end
    end
    check_output({tag, " frame ticks"}, 32'(ticks), 32'(exp_ticks));
    check_output({tag, " done"}, 32'(tx_done_tick), 32'd1);
    check_output({tag, " end busy"}, 32'(tx_busy), 32'd0);
    check_output({tag, " end tx"}, 32'(tx), 32'd1);
  endtask

  initial begin
    reset      = 1'b1;
    tx_start   = 1'b0;
    s_tick     = 1'b0;
    tx_din     = 8'h00;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop2  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset tx", 32'(tx), 32'd1);
    check_output("reset busy", 32'(tx_busy), 32'd0);
    check_output("reset done", 32'(tx_done_tick), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_output("idle tx", 32'(tx), 32'd1);
    check_output("idle busy", 32'(tx_busy), 32'd0);

    // 8N1, 0x55
    apply_stimulus("8N1", 8'h55, 4'd8, 2'b00, 1'b0);
    run_frame("8N1", 16'h00AA, 9, 160, -1);
    @(posedge clk);
    #1;
    check_output("8N1 done pulse width", 32'(tx_done_tick), 32'd0);

    // 7E2, 0xC1: bit 7 ignored, even parity of 0x41 is 0
    apply_stimulus("7E2", 8'hC1, 4'd7, 2'b01, 1'b1);
`ifdef UART_TX_PARITY_EN
    run_frame("7E2", 16'h0082, 9, 176, -1);
`else
    run_frame("7E2", 16'h0082, 8, 160, -1);
`endif
    repeat (3) @(posedge clk);
    #1;

    // 5O1, 0x1F: five ones, odd parity 0; dbits=3 clamps to 5
    apply_stimulus("5O1", 8'h1F, 4'd5, 2'b10, 1'b0);
`ifdef UART_TX_PARITY_EN
    run_frame("5O1", 16'h003E, 7, 128, -1);
`else
    run_frame("5O1", 16'h003E, 6, 112, -1);
`endif
    repeat (3) @(posedge clk);
    #1;
    apply_stimulus("5O1c", 8'h1F, 4'd3, 2'b10, 1'b0);
`ifdef UART_TX_PARITY_EN
    run_frame("5O1c", 16'h003E, 7, 128, -1);
`else
    run_frame("5O1c", 16'h003E, 6, 112, -1);
`endif
    repeat (3) @(posedge clk);
    #1;

    // dbits above DBIT_MAX clamps to 8
    apply_stimulus("8N1c", 8'h55, 4'd12, 2'b00, 1'b0);
    run_frame("8N1c", 16'h00AA, 9, 160, -1);
    repeat (3) @(posedge clk);
    #1;

    // tx_start mid-DATA with new data/config is ignored
    apply_stimulus("busy", 8'h55, 4'd8, 2'b00, 1'b0);
    run_frame("busy", 16'h00AA, 9, 160, 4);
    repeat (10) @(posedge clk);
    #1;
    check_output("no queued busy", 32'(tx_busy), 32'd0);
    check_output("no queued tx", 32'(tx), 32'd1);

    // tx_start in the done cycle starts the next frame immediately
    apply_stimulus("b2b1", 8'h55, 4'd8, 2'b00, 1'b0);
    run_frame("b2b1", 16'h00AA, 9, 160, -1);
    apply_stimulus("b2b2", 8'hA3, 4'd8, 2'b00, 1'b0);
    run_frame("b2b2", 16'h0146, 9, 160, -1);
    repeat (3) @(posedge clk);
    #1;

    // reset 8 ticks into the parity bit of a 7E1 frame
    apply_stimulus("rst", 8'h41, 4'd7, 2'b01, 1'b0);
    repeat (136) do_tick();
    reset = 1'b1;
    #1;
    check_output("rst async tx", 32'(tx), 32'd1);
    check_output("rst async busy", 32'(tx_busy), 32'd0);
    check_output("rst async done", 32'(tx_done_tick), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_output("rst after done", 32'(tx_done_tick), 32'd0);
    check_output("rst after busy", 32'(tx_busy), 32'd0);
    apply_stimulus("clean", 8'hA3, 4'd8, 2'b00, 1'b0);
    run_frame("clean", 16'h0146, 9, 160, -1);
    repeat (3) @(posedge clk);
    #1;

    // 8 bits with even parity requested on 0x57 (five ones)
    apply_stimulus("8E1", 8'h57, 4'd8, 2'b01, 1'b0);
`ifdef UART_TX_PARITY_EN
    run_frame("8E1", 16'h02AE, 10, 176, -1);
`else
    run_frame("8E1", 16'h00AE, 9, 160, -1);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
